// File: rtl/finalizer_lpf_scheduler.sv
// rtl/finalizer_lpf_scheduler.sv - time-multiplexed first-order IIR low-pass filter bank
// One shared signed MAC evaluates every channel once per sample period; outputs publish together.
module finalizer_lpf_scheduler #(
    parameter int CHANNELS = 4,
    parameter int DIV      = 128,
    parameter int COEF_W   = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [16*CHANNELS-1:0]     in_data,
    input  logic [CHANNELS-1:0]        ch_en,
    input  logic                       cfg_we,
    input  logic [2:0]                 cfg_ch,
    input  logic [1:0]                 cfg_sel,
    input  logic signed [COEF_W-1:0]   cfg_data,
    output logic [16*CHANNELS-1:0]     out_data,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NS = 1 << CW;
    localparam int DW = $clog2(DIV);
    localparam int PW = COEF_W + 16;
    localparam int AW = 36;
    localparam logic signed [COEF_W-1:0] B_DEF  = COEF_W'(1722);
    localparam logic signed [COEF_W-1:0] A2_DEF = COEF_W'(-29324);

    generate
        if (CHANNELS < 1 || CHANNELS > 8 || DIV < 4*CHANNELS+3) begin : g_param_chk
            $error("finalizer_lpf_scheduler: CHANNELS must be 1..8 and DIV >= 4*CHANNELS+3");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_WB, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [DW-1:0]             div_q, div_d;
    logic                      tick;
    logic [CW-1:0]             ch_q, ch_d;
    logic signed [COEF_W-1:0]  b1_q [NS];
    logic signed [COEF_W-1:0]  b1_d [NS];
    logic signed [COEF_W-1:0]  b2_q [NS];
    logic signed [COEF_W-1:0]  b2_d [NS];
    logic signed [COEF_W-1:0]  a2_q [NS];
    logic signed [COEF_W-1:0]  a2_d [NS];
    logic signed [COEF_W-1:0]  sh_b1_q [NS];
    logic signed [COEF_W-1:0]  sh_b1_d [NS];
    logic signed [COEF_W-1:0]  sh_b2_q [NS];
    logic signed [COEF_W-1:0]  sh_b2_d [NS];
    logic signed [COEF_W-1:0]  sh_a2_q [NS];
    logic signed [COEF_W-1:0]  sh_a2_d [NS];
    logic signed [15:0]        sh_x_q [NS];
    logic signed [15:0]        sh_x_d [NS];
    logic [NS-1:0]             sh_en_q, sh_en_d;
    logic signed [15:0]        x1_q [NS];
    logic signed [15:0]        x1_d [NS];
    logic signed [15:0]        y1_q [NS];
    logic signed [15:0]        y1_d [NS];
    logic signed [15:0]        res_q [NS];
    logic signed [15:0]        res_d [NS];
    logic signed [AW-1:0]      acc_q, acc_d;
    logic [16*CHANNELS-1:0]    out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;

    logic                      cfg_hit;
    logic signed [COEF_W-1:0]  coef_op;
    logic signed [15:0]        data_op;
    logic signed [PW-1:0]      coef_x, data_x, prod;
    logic signed [AW-1:0]      prod_ext, acc_sh;
    logic signed [15:0]        y_sat, x_cur;

    assign tick      = (div_q == DW'(DIV-1));
    assign div_d     = tick ? '0 : div_q + 1'b1;
    assign cfg_hit   = cfg_we && ({29'd0, cfg_ch} < 32'(CHANNELS));
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Live coefficients; only the snapshot copies feed the datapath.
    always_comb begin
        b1_d = b1_q;
        b2_d = b2_q;
        a2_d = a2_q;
        if (cfg_hit) begin
            case (cfg_sel)
                2'd0:    b1_d[cfg_ch[CW-1:0]] = cfg_data;
                2'd1:    b2_d[cfg_ch[CW-1:0]] = cfg_data;
                2'd2:    a2_d[cfg_ch[CW-1:0]] = cfg_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        coef_op = sh_b1_q[ch_q];
        data_op = sh_x_q[ch_q];
        case (state_q)
            S_MAC1: begin
                coef_op = sh_b2_q[ch_q];
                data_op = x1_q[ch_q];
            end
            S_MAC2: begin
                coef_op = sh_a2_q[ch_q];
                data_op = y1_q[ch_q];
            end
            default: ;
        endcase
    end

    assign coef_x   = {{16{coef_op[COEF_W-1]}}, coef_op};
    assign data_x   = {{COEF_W{data_op[15]}}, data_op};
    assign prod     = coef_x * data_x;
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign acc_sh   = acc_q >>> 15;
    assign x_cur    = sh_x_q[ch_q];

    always_comb begin
        if (acc_sh > 36'sd32767)
            y_sat = 16'sh7fff;
        else if (acc_sh < -36'sd32768)
            y_sat = 16'sh8000;
        else
            y_sat = acc_sh[15:0];
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        sh_b1_d     = sh_b1_q;
        sh_b2_d     = sh_b2_q;
        sh_a2_d     = sh_a2_q;
        sh_x_d      = sh_x_q;
        sh_en_d     = sh_en_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        res_d       = res_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    sh_b1_d = b1_q;
                    sh_b2_d = b2_q;
                    sh_a2_d = a2_q;
                    sh_en_d = NS'(ch_en);
                    for (int k = 0; k < CHANNELS; k++)
                        sh_x_d[k] = in_data[16*k +: 16];
                    ch_d    = '0;
                    state_d = S_MAC0;
                end
            end
            S_MAC0: begin
                acc_d   = prod_ext;
                state_d = S_MAC1;
            end
            S_MAC1: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_MAC2;
            end
            S_MAC2: begin
                acc_d   = acc_q - prod_ext;
                state_d = S_WB;
            end
            S_WB: begin
                // A disabled channel passes its input through and restarts from zero state.
                if (sh_en_q[ch_q]) begin
                    res_d[ch_q] = y_sat;
                    x1_d[ch_q]  = x_cur;
                    y1_d[ch_q]  = y_sat;
                end else begin
                    res_d[ch_q] = x_cur;
                    x1_d[ch_q]  = '0;
                    y1_d[ch_q]  = '0;
                end
                if (ch_q == CW'(CHANNELS-1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_MAC0;
                end
            end
            S_DONE: begin
                for (int k = 0; k < CHANNELS; k++)
                    out_data_d[16*k +: 16] = res_q[k];
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            sh_en_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                b1_q[k]    <= B_DEF;
                b2_q[k]    <= B_DEF;
                a2_q[k]    <= A2_DEF;
                sh_b1_q[k] <= B_DEF;
                sh_b2_q[k] <= B_DEF;
                sh_a2_q[k] <= A2_DEF;
                sh_x_q[k]  <= '0;
                x1_q[k]    <= '0;
                y1_q[k]    <= '0;
                res_q[k]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            sh_en_q     <= sh_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            a2_q        <= a2_d;
            sh_b1_q     <= sh_b1_d;
            sh_b2_q     <= sh_b2_d;
            sh_a2_q     <= sh_a2_d;
            sh_x_q      <= sh_x_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            res_q       <= res_d;
        end
    end

endmodule
